// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide sequencer: computes at issue, holds results through a fixed busy window, then commits HI/LO.
// Optional MDU_CANCEL_EN: a CP0 request while busy aborts the in-flight operation.
module e_mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  output logic        busy,
  output logic        MDUStall,
  output logic [31:0] MDUOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [3:0] MULT_N = MULT_CYCLES[3:0];
  localparam logic [3:0] DIV_N  = DIV_CYCLES[3:0];

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] phi_q, phi_d, plo_q, plo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, busy_d;

  // Arithmetic datapath; results are only captured on an accepted issue.
  logic [63:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
  logic        b_zero;
  logic [31:0] b_safe, a_mag, b_mag, q_mag, r_mag, quo_s, rem_s, quo_u, rem_u;

  always_comb begin
    a_sx   = {{32{A[31]}}, A};
    b_sx   = {{32{B[31]}}, B};
    a_zx   = {32'd0, A};
    b_zx   = {32'd0, B};
    prod_s = a_sx * b_sx;
    prod_u = a_zx * b_zx;
    b_zero = (B == 32'd0);
    // Substitute a harmless divisor for B=0 so the dividers never produce X.
    b_safe = b_zero ? 32'd1 : B;
    a_mag  = A[31] ? (32'd0 - A) : A;
    b_mag  = b_safe[31] ? (32'd0 - b_safe) : b_safe;
    q_mag  = a_mag / b_mag;
    r_mag  = a_mag % b_mag;
    quo_s  = (A[31] ^ b_safe[31]) ? (32'd0 - q_mag) : q_mag;
    rem_s  = A[31] ? (32'd0 - r_mag) : r_mag;
    quo_u  = A / b_safe;
    rem_u  = A % b_safe;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (start && !Req) begin
          case (MDUOp)
            OP_MULT, OP_MULTU: begin
              {phi_d, plo_d} = (MDUOp == OP_MULT) ? prod_s : prod_u;
              cnt_d   = MULT_N;
              busy_d  = 1'b1;
              state_d = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              // A zero divisor re-commits the current HI/LO, leaving them unchanged.
              if (b_zero) begin
                phi_d = hi_q;
                plo_d = lo_q;
              end else if (MDUOp == OP_DIV) begin
                phi_d = rem_s;
                plo_d = quo_s;
              end else begin
                phi_d = rem_u;
                plo_d = quo_u;
              end
              cnt_d   = DIV_N;
              busy_d  = 1'b1;
              state_d = S_RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
`ifdef MDU_CANCEL_EN
        if (Req) begin
          cnt_d   = 4'd0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else
`endif
        begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            cnt_d   = 4'd0;
            hi_d    = phi_q;
            lo_d    = plo_q;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign MDUStall = (start && (MDUOp >= OP_MULT) && (MDUOp <= OP_MFLO)) || busy_q;
  assign MDUOut   = (start && MDUOp == OP_MFHI) ? hi_q :
                    (start && MDUOp == OP_MFLO) ? lo_q : 32'd0;

endmodule
